// File: rtl/prv32_alu_arbiter.sv
// Two-requester arbiter in front of the shared prv32 ALU: an operand stage drives the ALU, a response stage captures its result.
// Build option PRV32_ALU_ARB_RR_EN: round-robin between requesters; left undefined, requester 0 has fixed priority.
module prv32_alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [4:0]      req0_shamt,
    input  logic [3:0]      req0_alufn,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [4:0]      req1_shamt,
    input  logic [3:0]      req1_alufn,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_shamt,
    output logic [3:0]      alu_alufn,
    input  logic [XLEN-1:0] alu_r,
    input  logic            alu_cf,
    input  logic            alu_zf,
    input  logic            alu_vf,
    input  logic            alu_sf,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_r,
    output logic [3:0]      rsp_flags
);

    logic            vld_p0;
    logic            id_p0;
    logic            advance;
    logic            take;
    logic            grant;
    logic            accept;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [4:0]      sel_shamt;
    logic [3:0]      sel_alufn;

`ifdef PRV32_ALU_ARB_RR_EN
    logic prio;

    // On contention prio names the winner; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = prio;
        else if (req1_valid)
            grant = 1'b1;
    end
`else
    always_comb begin
        grant = 1'b0;
        if (!req0_valid && req1_valid)
            grant = 1'b1;
    end
`endif

    // Readiness looks through both stages to rsp_ready, so a drained pipe accepts every cycle.
    always_comb begin
        advance    = !rsp_valid || rsp_ready;
        take       = !vld_p0 || advance;
        req0_ready = !rst && take && !grant;
        req1_ready = !rst && take && grant;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    always_comb begin
        sel_a     = req0_a;
        sel_b     = req0_b;
        sel_shamt = req0_shamt;
        sel_alufn = req0_alufn;
        if (grant) begin
            sel_a     = req1_a;
            sel_b     = req1_b;
            sel_shamt = req1_shamt;
            sel_alufn = req1_alufn;
        end
    end

    // ---- operand stage (p0): registered ALU inputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            id_p0     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_shamt <= '0;
            alu_alufn <= '0;
        end else if (take) begin
            vld_p0 <= accept;
            if (accept) begin
                id_p0     <= grant;
                alu_a     <= sel_a;
                alu_b     <= sel_b;
                alu_shamt <= sel_shamt;
                alu_alufn <= sel_alufn;
            end
        end
    end

`ifdef PRV32_ALU_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (accept)
            prio <= !grant;
    end
`endif

    // ---- response stage (p1): captured ALU result and flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_flags <= '0;
        end else if (advance) begin
            rsp_valid <= vld_p0;
            if (vld_p0) begin
                rsp_id    <= id_p0;
                rsp_r     <= alu_r;
                rsp_flags <= {alu_cf, alu_zf, alu_vf, alu_sf};
            end
        end
    end

endmodule
